// File: rtl/jpeg_block_compressor.sv
// jpeg_block_compressor
//   Accepts one 8x8 block of unsigned pixels in raster order and computes the
//   2-D DCT-II with a single time-shared multiply-accumulate unit: a row pass
//   of 512 MACs, then a column pass of 512 MACs. Each coefficient is quantised
//   against the luma or chroma JPEG table using a reciprocal multiply. The
//   quantised block is emitted in zigzag order.
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : pixel handshake; in_data is the pixel, qsel picks the
//                          quant table and is sampled with pixel 0
//   out_valid/out_ready  : coefficient handshake; out_data is the quantised
//                          coefficient, out_index its raster index u*8+v, and
//                          out_last marks the 64th coefficient
//   busy                 : block is being transformed or emitted
module jpeg_block_compressor #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned FRAC_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              qsel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic [5:0]        out_index,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned S_W   = DATA_W + 1;
  localparam int unsigned T_W   = DATA_W + 4;
  localparam int unsigned C_W   = FRAC_W + 2;
  localparam int unsigned P_W   = T_W + C_W;
  localparam int unsigned ACC_W = DATA_W + FRAC_W + 8;
  localparam int unsigned F_W   = DATA_W + 6;
  localparam int unsigned Q_W   = F_W + 18;

  localparam logic signed [ACC_W-1:0] RND_C  = ACC_W'(1) << (FRAC_W - 1);
  localparam logic signed [Q_W-1:0]   QRND_C = Q_W'(32768);
  localparam logic signed [Q_W-1:0]   QMAX_C = Q_W'((longint'(1) <<< (COEF_W - 1)) - 1);
  localparam logic signed [Q_W-1:0]   QMIN_C = -QMAX_C - Q_W'(1);

  localparam int unsigned Q_LUMA [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99};

  localparam int unsigned Q_CHROMA [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99};

  localparam int unsigned ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_t;

  // Cosine constant C(k,n). The angle (2n+1)k*pi/16 is folded into the first
  // quadrant; base magnitudes are held with 15 fractional bits and rounded to
  // FRAC_W. Negative entries are rounded symmetrically so opposite pairs cancel.
  function automatic logic signed [C_W-1:0] cos_rom(input logic [2:0] k,
                                                    input logic [2:0] n);
    int  m;
    int  v;
    int  sh;
    logic neg;
    m   = ((2 * int'(n) + 1) * int'(k)) % 32;
    neg = 1'b0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1'b1;
    end
    case (m)
      0:       v = 16384;
      1:       v = 16069;
      2:       v = 15137;
      3:       v = 13623;
      4:       v = 11585;
      5:       v = 9102;
      6:       v = 6270;
      7:       v = 3196;
      default: v = 0;
    endcase
    if (k == 3'd0) v = 11585;
    sh = 15 - int'(FRAC_W);
    if (sh > 0) v = (v + (1 <<< (sh - 1))) >>> sh;
    else if (sh < 0) v = v <<< (-sh);
    if (neg) v = -v;
    return C_W'(v);
  endfunction

  state_t                    r_state, w_state_nxt;
  logic [5:0]                r_pix;
  logic [8:0]                r_mac;
  logic [5:0]                r_zz;
  logic                      r_qsel;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [S_W-1:0]     r_sbuf [64];
  logic signed [T_W-1:0]     r_tbuf [64];
  logic [COEF_W-1:0]         r_qbuf [64];

  logic                      w_accept;
  logic [S_W-1:0]            w_pix_s;
  logic [2:0]                w_k, w_n;
  logic [5:0]                w_op_addr, w_res_addr, w_zz_addr;
  logic signed [T_W-1:0]     w_opnd;
  logic signed [C_W-1:0]     w_coef;
  logic signed [P_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]   w_sum, w_rnd;
  logic signed [F_W-1:0]     w_f;
  logic [15:0]               w_recip_l [64];
  logic [15:0]               w_recip_c [64];
  logic [15:0]               w_recip;
  logic signed [Q_W-1:0]     w_qprod, w_q;
  logic [COEF_W-1:0]         w_qsat;

  for (genvar gi = 0; gi < 64; gi++) begin : g_recip
    localparam int unsigned RL = (65536 + Q_LUMA[gi] / 2) / Q_LUMA[gi];
    localparam int unsigned RC = (65536 + Q_CHROMA[gi] / 2) / Q_CHROMA[gi];
    assign w_recip_l[gi] = 16'(RL);
    assign w_recip_c[gi] = 16'(RC);
  end

  assign w_accept  = in_valid & in_ready;
  assign w_pix_s   = {1'b0, in_data} - {2'b01, {(DATA_W - 1){1'b0}}};
  assign w_k       = r_mac[5:3];
  assign w_n       = r_mac[2:0];
  assign w_res_addr = {r_mac[8:6], r_mac[5:3]};
  assign w_zz_addr = 6'(ZIGZAG[r_zz]);

  // One shared MAC. Row pass: index {x,u,y}, operand s(x,y), coef C(u,y).
  // Column pass: index {u,v,x}, operand T(x,u), coef C(v,x). The sum is
  // restarted on the first term and written out on the eighth.
  always_comb begin
    w_op_addr = (r_state == COL) ? {r_mac[2:0], r_mac[8:6]} : {r_mac[8:6], r_mac[2:0]};
    w_opnd    = (r_state == COL) ? r_tbuf[w_op_addr] : T_W'(r_sbuf[w_op_addr]);
    w_coef    = cos_rom(w_k, w_n);
    w_prod    = w_opnd * w_coef;
    w_sum     = ACC_W'(w_prod);
    if (w_n != 3'd0) w_sum = r_acc + ACC_W'(w_prod);
    w_rnd     = (w_sum + RND_C) >>> FRAC_W;
    w_f       = F_W'(w_rnd);
    w_recip   = r_qsel ? w_recip_c[w_res_addr] : w_recip_l[w_res_addr];
    w_qprod   = Q_W'(w_f) * Q_W'($signed({1'b0, w_recip}));
    w_q       = (w_qprod + QRND_C) >>> 16;
    if (w_q > QMAX_C)      w_qsat = COEF_W'(QMAX_C);
    else if (w_q < QMIN_C) w_qsat = COEF_W'(QMIN_C);
    else                   w_qsat = COEF_W'(w_q);
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_index   = '0;
    out_data    = '0;
    busy        = 1'b1;
    case (r_state)
      LOAD: begin
        busy     = 1'b0;
        in_ready = rst_n;
        if (in_valid && rst_n && r_pix == 6'd63) w_state_nxt = ROW;
      end
      ROW: if (r_mac == '1) w_state_nxt = COL;
      COL: if (r_mac == '1) w_state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        out_index = w_zz_addr;
        out_data  = r_qbuf[w_zz_addr];
        out_last  = (r_zz == '1);
        if (out_ready && r_zz == '1) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_pix   <= '0;
      r_mac   <= '0;
      r_zz    <= '0;
      r_acc   <= '0;
      r_qsel  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pix <= r_pix + 6'd1;
        if (r_pix == '0) r_qsel <= qsel;
      end
      if (r_state == ROW || r_state == COL) begin
        r_mac <= r_mac + 9'd1;
        r_acc <= w_sum;
      end
      if (out_valid && out_ready) r_zz <= r_zz + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_sbuf[r_pix] <= $signed(w_pix_s);
    if (r_state == ROW && w_n == 3'd7) r_tbuf[w_res_addr] <= T_W'(w_rnd);
    if (r_state == COL && w_n == 3'd7) r_qbuf[w_res_addr] <= w_qsat;
  end

endmodule
